// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU operations,
// opcodes, R-type funct codes and the 4-bit FSM state codes.
// Build option MULTICYCLE_CTRL_ILLEGAL_TRAP_EN selects trap-to-HALT handling
// of illegal instructions; see multicycle_ctrl.sv.
package multicycle_ctrl_pkg;

  // ALU operation select driven onto alu_op
  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_AND = 3'd2;
  localparam logic [2:0] ALUOP_OR  = 3'd3;
  localparam logic [2:0] ALUOP_NOR = 3'd4;
  localparam logic [2:0] ALUOP_SLT = 3'd5;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // FSM state codes, exported on the state debug port
  typedef enum logic [3:0] {
    ST_IF       = 4'd0,
    ST_ID       = 4'd1,
    ST_EXE_R    = 4'd2,
    ST_EXE_I    = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_BEQ      = 4'd10,
    ST_JMP      = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation and flags any funct
// the datapath does not implement. Purely combinational.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       fn_illegal
);

  // funct lookup; unknown codes fall back to ADD and raise fn_illegal
  always_comb begin
    alu_op     = ALUOP_ADD;
    fn_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALUOP_ADD;
      FN_SUB:  alu_op = ALUOP_SUB;
      FN_AND:  alu_op = ALUOP_AND;
      FN_OR:   alu_op = ALUOP_OR;
      FN_NOR:  alu_op = ALUOP_NOR;
      FN_SLT:  alu_op = ALUOP_SLT;
      default: fn_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM. Moore outputs from the state register, with
// the IF handshake (mem_ready) and the beq decision (zero) as the only Mealy
// terms. Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions
// in HALT; otherwise they execute as a NOP with a one-cycle illegal pulse.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] rtype_op;
  logic       fn_illegal;

  // Ungated write enables; reset masks them before they leave the block
  logic pc_we_c;
  logic ir_we_c;
  logic mem_we_c;
  logic reg_we_c;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alu_op     (rtype_op),
    .fn_illegal (fn_illegal)
  );

  // State register with synchronous active-low reset back to fetch
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IF;
    else        state_reg <= state_next;
  end

  // Next-state and per-state control decode
  always_comb begin
    state_next = state_reg;
    pc_we_c    = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_re     = 1'b0;
    mem_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state_reg)
      ST_IF: begin
        // Fetch and PC+4 happen together on the cycle memory answers
        mem_re    = 1'b1;
        alu_src_b = 2'd1;
        pc_we_c   = mem_ready;
        ir_we_c   = mem_ready;
        if (mem_ready) state_next = ST_ID;
      end
      ST_ID: begin
        // Branch target PC + (imm<<2) lands in ALUOut while decoding
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:      state_next = ST_EXE_R;
          OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
          OP_BEQ:        state_next = ST_BEQ;
          OP_J:          state_next = ST_JMP;
          OP_ADDI,
          OP_ORI:        state_next = ST_EXE_I;
          default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            state_next = ST_HALT;
`else
            illegal    = 1'b1;
            state_next = ST_IF;
`endif
          end
        endcase
      end
      ST_EXE_R: begin
        alu_src_a = 1'b1;
        if (fn_illegal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_next = ST_HALT;
`else
          illegal    = 1'b1;
          state_next = ST_IF;
`endif
        end else begin
          alu_op     = rtype_op;
          state_next = ST_WB_R;
        end
      end
      ST_WB_R: begin
        reg_we_c   = 1'b1;
        reg_dst    = 1'b1;
        state_next = ST_IF;
      end
      ST_EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OP_ORI) begin
          alu_op   = ALUOP_OR;
          ext_zero = 1'b1;
        end
        state_next = ST_WB_I;
      end
      ST_WB_I: begin
        reg_we_c   = 1'b1;
        state_next = ST_IF;
      end
      ST_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        state_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        iord   = 1'b1;
        mem_re = 1'b1;
        if (mem_ready) state_next = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        iord     = 1'b1;
        mem_we_c = 1'b1;
        if (mem_ready) state_next = ST_IF;
      end
      ST_WB_MEM: begin
        reg_we_c   = 1'b1;
        mem_to_reg = 1'b1;
        state_next = ST_IF;
      end
      ST_BEQ: begin
        // Compare rs-rt; take the precomputed target only when equal
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = 2'd1;
        pc_we_c    = zero;
        state_next = ST_IF;
      end
      ST_JMP: begin
        pc_src     = 2'd2;
        pc_we_c    = 1'b1;
        state_next = ST_IF;
      end
      ST_HALT: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal    = 1'b1;
        state_next = ST_HALT;
`else
        state_next = ST_IF;
`endif
      end
      default: state_next = ST_IF;
    endcase
  end

  // Reset abandons the instruction: no architectural write may escape
  assign pc_we  = pc_we_c  & rst_n;
  assign ir_we  = ir_we_c  & rst_n;
  assign mem_we = mem_we_c & rst_n;
  assign reg_we = reg_we_c & rst_n;

  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl. Each instruction is expanded into the
// per-cycle control pattern it should produce (including memory waits, beq
// outcome and optional mid-instruction reset), then replayed and compared.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  // Reference encodings, written out independently of the design package
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2,
                         A_OR  = 3'd3, A_NOR = 3'd4, A_SLT = 3'd5;
  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EXR = 4'd2, S_EXI = 4'd3,
                         S_MA = 4'd4, S_MRD = 4'd5, S_MWR = 4'd6, S_WBM = 4'd7,
                         S_WBR = 4'd8, S_WBI = 4'd9, S_BEQ = 4'd10, S_JMP = 4'd11,
                         S_HALT = 4'd12;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t       e;
    bit         mr;
    bit         z;
    bit         rn;
    logic [5:0] op;
    logic [5:0] fn;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_zero, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int    total = 0;
  int    bad   = 0;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op),
    .illegal(illegal), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    c.alu_op = A_ADD;
    return c;
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B};
  endfunction

  task automatic push(input ctl_t e, input bit mr, input bit z, input bit rn,
                      input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.e = e; s.mr = mr; s.z = z; s.rn = rn; s.op = op; s.fn = fn;
    q.push_back(s);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Illegal instruction outcome: NOP with pulse, or HALT until reset
  task automatic illegal_tail(input ctl_t c, input logic [5:0] op, input logic [5:0] fn);
    ctl_t h;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    push(c, rb(), rb(), 1'b1, op, fn);
    h = blank(S_HALT);
    h.illegal = 1'b1;
    repeat (3) push(h, rb(), rb(), 1'b1, op, fn);
    push(h, rb(), rb(), 1'b0, op, fn);
`else
    c.illegal = 1'b1;
    push(c, rb(), rb(), 1'b1, op, fn);
`endif
  endtask

  // Expand one instruction into its expected per-cycle behaviour.
  // rst_mem: assert reset on the second cycle of the memory access stage.
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int w_if, input int w_mem, input bit z, input bit rst_mem);
    ctl_t c;
    bit   fn_ok;
    logic [2:0] fop;
    // Fetch: opcode on the bus is junk until IR loads
    c = blank(S_IF);
    c.mem_re = 1'b1;
    c.alu_src_b = 2'd1;
    for (int i = 0; i < w_if; i++) push(c, 1'b0, rb(), 1'b1, 6'($urandom), 6'($urandom));
    c.pc_we = 1'b1;
    c.ir_we = 1'b1;
    push(c, 1'b1, rb(), 1'b1, 6'($urandom), 6'($urandom));
    // Decode
    c = blank(S_ID);
    c.alu_src_b = 2'd3;
    if (!legal_op(op)) begin
      illegal_tail(c, op, fn);
      return;
    end
    push(c, rb(), rb(), 1'b1, op, fn);
    case (op)
      6'h00: begin
        fn_ok = 1'b1;
        fop = A_ADD;
        case (fn)
          6'h20: fop = A_ADD;
          6'h22: fop = A_SUB;
          6'h24: fop = A_AND;
          6'h25: fop = A_OR;
          6'h27: fop = A_NOR;
          6'h2A: fop = A_SLT;
          default: fn_ok = 1'b0;
        endcase
        c = blank(S_EXR);
        c.alu_src_a = 1'b1;
        if (!fn_ok) begin
          illegal_tail(c, op, fn);
          return;
        end
        c.alu_op = fop;
        push(c, rb(), rb(), 1'b1, op, fn);
        c = blank(S_WBR);
        c.reg_we = 1'b1;
        c.reg_dst = 1'b1;
        push(c, rb(), rb(), 1'b1, op, fn);
      end
      6'h08, 6'h0D: begin
        c = blank(S_EXI);
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        if (op == 6'h0D) begin
          c.alu_op = A_OR;
          c.ext_zero = 1'b1;
        end
        push(c, rb(), rb(), 1'b1, op, fn);
        c = blank(S_WBI);
        c.reg_we = 1'b1;
        push(c, rb(), rb(), 1'b1, op, fn);
      end
      6'h23, 6'h2B: begin
        c = blank(S_MA);
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        push(c, rb(), rb(), 1'b1, op, fn);
        c = blank(op == 6'h23 ? S_MRD : S_MWR);
        c.iord = 1'b1;
        if (op == 6'h23) c.mem_re = 1'b1;
        else             c.mem_we = 1'b1;
        if (rst_mem) begin
          push(c, 1'b0, rb(), 1'b1, op, fn);
          c.mem_we = 1'b0;
          push(c, rb(), rb(), 1'b0, op, fn);
          return;
        end
        for (int i = 0; i < w_mem; i++) push(c, 1'b0, rb(), 1'b1, op, fn);
        push(c, 1'b1, rb(), 1'b1, op, fn);
        if (op == 6'h23) begin
          c = blank(S_WBM);
          c.reg_we = 1'b1;
          c.mem_to_reg = 1'b1;
          push(c, rb(), rb(), 1'b1, op, fn);
        end
      end
      6'h04: begin
        c = blank(S_BEQ);
        c.alu_src_a = 1'b1;
        c.alu_op = A_SUB;
        c.pc_src = 2'd1;
        c.pc_we = z;
        push(c, rb(), z, 1'b1, op, fn);
      end
      default: begin
        c = blank(S_JMP);
        c.pc_src = 2'd2;
        c.pc_we = 1'b1;
        push(c, rb(), rb(), 1'b1, op, fn);
      end
    endcase
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ctl_t  got;
    step_t s;
    int    n;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_state", 32'(state), 32'(S_IF));
    check("rst_we", 32'({pc_we, ir_we, mem_we, reg_we}), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;

    // Directed cases from the test plan
    gen_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b0);   // add
    gen_instr(6'h23, 6'h00, 0, 2, 1'b0, 1'b0);   // lw, 2 wait cycles
    gen_instr(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);   // beq taken
    gen_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);   // beq not taken
    gen_instr(6'h0D, 6'h00, 0, 0, 1'b0, 1'b0);   // ori
    gen_instr(6'h08, 6'h00, 1, 0, 1'b0, 1'b0);   // addi after a fetch wait
    gen_instr(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);   // illegal opcode
    gen_instr(6'h2B, 6'h00, 0, 0, 1'b0, 1'b1);   // sw with reset in MEM_WR
    gen_instr(6'h00, 6'h3F, 0, 0, 1'b0, 1'b0);   // illegal funct
    gen_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0);   // j

    // Random instruction mix
    for (int k = 0; k < 250; k++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom);
        if (legal_op(op)) op = 6'h3E;
      end
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) begin
        fn = 6'($urandom);
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) fn = 6'h3F;
      end
      gen_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rb(),
                ($urandom_range(0, 11) == 0));
    end

    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      rst_n = s.rn; mem_ready = s.mr; zero = s.z; opcode = s.op; funct = s.fn;
      @(negedge clk);
      got = {state, pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, illegal};
      check($sformatf("cyc%0d_st%0d_op%02h", n, s.e.st, s.op), 32'(got), 32'(s.e));
      @(posedge clk);
      #1;
      n++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the MIPS datapath: a Moore state machine, with one Mealy branch term, that decodes the latched instruction's opcode/funct into per-cycle datapath controls. It drives the ALU's `alu_op` select and consumes the ALU's `zero` flag to resolve `beq`. It sits between the instruction register and the datapath muxes, register file, memory port and PC.

## Interface
Parameters:
- none. ALU op and opcode/funct encodings come from `ctrl_def.v`.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26]; stable from the cycle after `ir_we`.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag.
- `mem_ready` in 1: memory handshake; access completes in a cycle where it is high.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: next-PC select. 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_re` out 1: memory read request.
- `mem_we` out 1: memory write request.
- `ir_we` out 1: instruction register load.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back select. 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select. 0 = rt, 1 = const 4, 2 = extended imm, 3 = extended imm<<2.
- `ext_zero` out 1: immediate extension. 1 = zero-extend (`ori`), 0 = sign-extend.
- `alu_op` out 3: ALU operation, using the `` `ALUOP_* `` encodings.
- `illegal` out 1: unsupported opcode/funct seen (see Configuration).
- `state` out 4: current state, for debug and the bench.

## Operation
- States: IF, ID, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_R, WB_I, BEQ, JMP, HALT.
- **IF**
  - Outputs: `mem_re`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_src`=0.
  - `ir_we` and `pc_we` equal `mem_ready`.
  - Stays in IF until `mem_ready`, then goes to ID.
- **ID**
  - Outputs: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=ADD. This precomputes the branch target into ALUOut.
  - Dispatch: R-type goes to EXE_R; `lw`/`sw` go to MEM_ADDR; `beq` goes to BEQ; `j` goes to JMP; `addi`/`ori` go to EXE_I.
  - Any other opcode is an illegal case (see Configuration).
- **EXE_R**
  - Outputs: `alu_src_a`=1, `alu_src_b`=0.
  - `alu_op` from funct: add→ADD, sub→SUB, and→AND, or→OR, nor→NOR, slt→SLT. Any other funct is illegal.
  - Next state: WB_R.
- **WB_R**: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Next state: IF.
- **EXE_I**
  - Outputs: `alu_src_a`=1, `alu_src_b`=2.
  - `addi`: `alu_op`=ADD, `ext_zero`=0. `ori`: `alu_op`=OR, `ext_zero`=1.
  - Next state: WB_I.
- **WB_I**: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. Next state: IF.
- **MEM_ADDR**: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=ADD. `lw` goes to MEM_RD; `sw` goes to MEM_WR.
- **MEM_RD**: `iord`=1, `mem_re`=1. Held until `mem_ready`, then goes to WB_MEM.
- **MEM_WR**: `iord`=1, `mem_we`=1. Held until `mem_ready`, then goes to IF.
- **WB_MEM**: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Next state: IF.
- **BEQ**
  - Outputs: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=SUB, `pc_src`=1.
  - `pc_we` = `zero`, combinationally in this state only.
  - Next state: IF.
- **JMP**: `pc_src`=2, `pc_we`=1. Next state: IF.
- **Defaults**: every output not named in a state is 0, and `alu_op` defaults to ADD.
- **Write enables**: `pc_we`, `ir_we`, `mem_we` and `reg_we` are forced to 0 while `rst_n`=0, regardless of state.

## Timing
- **Reset**
  - The edge with `rst_n`=0 sets `state`=IF and `illegal`=0.
  - Reset asserted mid-instruction (any state, including a wait on `mem_ready`) abandons the instruction. The PC and register file are not written.
- **Cycles per instruction**, with `mem_ready` tied high:
  - R-type: 4
  - `addi`/`ori`: 4
  - `lw`: 5
  - `sw`: 4
  - `beq`: 3
  - `j`: 3
- **Wait states**: each low cycle of `mem_ready` in IF, MEM_RD or MEM_WR adds exactly one cycle. Control outputs are held constant during the wait.
- **Output timing**: `state` is registered. All other outputs are combinational from `state`, `opcode` and `funct`, plus `zero` (BEQ only) and `mem_ready` (IF only).
- **Opcode sampling**: `opcode` is sampled only in ID and later. Its value during IF is ignored.

## Configuration
- Macro: `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN`.
- **Defined**
  - An illegal opcode (in ID) or funct (in EXE_R) moves the FSM to HALT.
  - HALT sets `illegal`=1, asserts no enables, and is left only by reset.
- **Undefined**
  - An illegal instruction returns to IF with no register or memory write; it executes as a NOP.
  - `illegal` pulses high for that one cycle.
  - HALT is unreachable.

## Structure
- In `ctrl_def.v`:
  - `` `ALUOP_* `` (already present).
  - New `` `OP_RTYPE ``, `` `OP_LW ``, `` `OP_SW ``, `` `OP_BEQ ``, `` `OP_J ``, `` `OP_ADDI ``, `` `OP_ORI ``.
  - `` `FN_ADD ``/`SUB`/`AND`/`OR`/`NOR`/`SLT`.
  - `` `ST_* `` state codes, 4-bit.
- Sub-module `alu_decoder`: combinational funct→`alu_op` mapping plus the funct-illegal flag, instantiated once.
- Top: the state register, next-state logic and output decode.

## Test plan
- **add**: `opcode`=0, `funct`=0x20, `mem_ready`=1 → states IF, ID, EXE_R, WB_R, IF. `alu_op`=ADD in EXE_R; `reg_we`=1 and `reg_dst`=1 in the 4th cycle.
- **lw with waits**: `opcode`=0x23, `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total. `mem_re`=1 and `iord`=1 held through the waits; `mem_to_reg`=1 in WB_MEM.
- **beq resolution**: `opcode`=0x04 in BEQ.
  - `zero`=1 → `pc_we`=1 with `pc_src`=1.
  - `zero`=0 → `pc_we`=0.
  - Both cases return to IF after 3 cycles.
- **ori extension**: `opcode`=0x0D → EXE_I with `alu_op`=OR and `ext_zero`=1. `addi` (0x08) gives `ext_zero`=0.
- **illegal opcode** 0x3F:
  - With the macro: `state`=HALT and `illegal` stays 1 until `rst_n`=0.
  - Without the macro: back to IF with a one-cycle `illegal` pulse and no write enables asserted.
- **reset mid-instruction**: `rst_n`=0 during MEM_WR → the next state is IF and `mem_we`=0 in the reset cycle.
